nios_buffer_dpram: RTL and testbench

//  Parametrised dual-port on-chip buffer RAM for the Nios buffer subsystem, with two independent

---
 rtl/nios_buffer_pkg.sv | 15 +
 rtl/nios_buffer_dpram_port.sv | 57 +++++
 rtl/nios_buffer_dpram.sv | 93 +++++++++
 tb/tb_nios_buffer_dpram.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nios_buffer_pkg.sv
// nios_buffer_pkg: shared state type and parameter checks for the Nios buffer RAM
package nios_buffer_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int BYTE_W = 8;
  localparam int DEF_BE_W = 32 / BYTE_W;
  function automatic bit addr_w_ok(input int depth, input int addr_w);
    return depth >= 1 && addr_w >= 1 && addr_w <= 30 && depth <= (1 << addr_w);
  endfunction
  function automatic bit latency_ok(input int lat);
    return lat == 1 || lat == 2;
  endfunction
  function automatic int idx_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/nios_buffer_dpram_port.sv
// nios_buffer_dpram_port: Avalon-MM slave front end with acceptance, range masking and read latency pipeline
module nios_buffer_dpram_port
  import nios_buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH = 10240,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic              stall,
  input  logic [DATA_W-1:0] q,
  output logic              we,
  output logic              re,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);
  logic acc, in_range, zero_q;
  logic [DATA_W-1:0] raw;
  assign acc = chipselect && (read || write) && !stall;
  assign in_range = 32'(address) < DEPTH;
  assign we = acc && write && in_range;
  assign re = acc && read && !write;
  assign raw = zero_q ? '0 : q;
  always_ff @(posedge clk or posedge reset)
    if (reset) zero_q <= 1'b1;
    else if (re) zero_q <= !in_range;
  if (!latency_ok(READ_LATENCY)) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end
  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0] v;
    logic [DATA_W-1:0] dout;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        v <= '0;
        dout <= '0;
      end else begin
        v <= {v[0], re};
        if (v[0]) dout <= raw;
      end
    assign readdatavalid = v[1];
    assign readdata = dout;
  end else begin : g_lat1
    logic v;
    always_ff @(posedge clk or posedge reset)
      if (reset) v <= 1'b0;
      else v <= re;
    assign readdatavalid = v;
    assign readdata = raw;
  end
endmodule

// File: rtl/nios_buffer_dpram.sv
// nios_buffer_dpram: dual-port Avalon-MM buffer RAM with zero-clear sweep and s1-priority write collisions
module nios_buffer_dpram
  import nios_buffer_pkg::*;
#(
  parameter int    DATA_W = 32,
  parameter int    DEPTH = 10240,
  parameter int    ADDR_W = 14,
  parameter int    READ_LATENCY = 1,
  parameter bit    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE = "Nios_Buffer_SRAM.hex",
  localparam int   BE_W = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic              s1_waitrequest,
  input  logic [ADDR_W-1:0] s2_address,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [BE_W-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid,
  output logic              s2_waitrequest,
  output logic              init_done
);
  localparam int AW = idx_w(DEPTH);
  if (!addr_w_ok(DEPTH, ADDR_W)) begin : g_bad_aw
    $error("ADDR_W too small for DEPTH");
  end
  if (!CLEAR_ON_RESET && INIT_FILE != "") begin : g_no_preload
    $warning("INIT_FILE is not loaded by this RTL; contents start undefined");
  end
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic run, clearing, p1_we, p2_we, we1, we2, re1, re2;
  logic [AW-1:0] ai1, ai2;
  logic [BE_W-1:0] be1, be2;
  logic [DATA_W-1:0] wd1, q1, q2;
  logic [DATA_W-1:0] mem [DEPTH];
  assign run = state == RUN;
  assign clearing = state == CLEAR && CLEAR_ON_RESET;
  assign s1_waitrequest = !run;
  assign s2_waitrequest = !run;
  assign init_done = run;
  always_comb
    state_nx = (state == CLEAR && (!CLEAR_ON_RESET || clr_cnt == ADDR_W'(DEPTH - 1))) ? RUN : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (clearing) clr_cnt <= clr_cnt + 1'b1;
    end
  assign ai1 = clearing ? clr_cnt[AW-1:0] : s1_address[AW-1:0];
  assign ai2 = s2_address[AW-1:0];
  assign we1 = clearing || p1_we;
  assign we2 = p2_we;
  assign be1 = clearing ? '1 : s1_byteenable;
  assign wd1 = clearing ? '0 : s1_writedata;
  assign be2 = (we1 && we2 && ai1 == ai2) ? s2_byteenable & ~be1 : s2_byteenable;
  always_ff @(posedge clk) begin
    if (re1) q1 <= mem[ai1];
    if (re2) q2 <= mem[ai2];
    for (int b = 0; b < BE_W; b++) begin
      if (we1 && be1[b]) mem[ai1][BYTE_W*b +: BYTE_W] <= wd1[BYTE_W*b +: BYTE_W];
      if (we2 && be2[b]) mem[ai2][BYTE_W*b +: BYTE_W] <= s2_writedata[BYTE_W*b +: BYTE_W];
    end
  end
  nios_buffer_dpram_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(READ_LATENCY)
  ) u_p1 (
    .clk(clk), .reset(reset), .address(s1_address), .chipselect(s1_chipselect),
    .read(s1_read), .write(s1_write), .stall(!run), .q(q1), .we(p1_we), .re(re1),
    .readdata(s1_readdata), .readdatavalid(s1_readdatavalid)
  );
  nios_buffer_dpram_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(READ_LATENCY)
  ) u_p2 (
    .clk(clk), .reset(reset), .address(s2_address), .chipselect(s2_chipselect),
    .read(s2_read), .write(s2_write), .stall(!run), .q(q2), .we(p2_we), .re(re2),
    .readdata(s2_readdata), .readdatavalid(s2_readdatavalid)
  );
endmodule

// File: tb/tb_nios_buffer_dpram.sv
// tb_nios_buffer_dpram: directed checks of clear sweep, latency, collisions and range handling
module tb_nios_buffer_dpram;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic a_reset, b_reset;
  logic [3:0] a1_addr, a2_addr, a1_be, a2_be, b1_be, b2_be;
  logic a1_cs, a1_rd, a1_wr, a2_cs, a2_rd, a2_wr, a1_v, a2_v, a1_wait, a2_wait, a_done;
  logic [31:0] a1_wd, a2_wd, a1_q, a2_q, b1_wd, b2_wd, b1_q, b2_q;
  logic [4:0] b1_addr, b2_addr;
  logic b1_cs, b1_rd, b1_wr, b2_cs, b2_rd, b2_wr, b1_v, b2_v, b1_wait, b2_wait, b_done;
  logic [31:0] exp_a [10];
  nios_buffer_dpram #(.DATA_W(32), .DEPTH(10), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) ua (
    .clk(clk), .reset(a_reset),
    .s1_address(a1_addr), .s1_chipselect(a1_cs), .s1_read(a1_rd), .s1_write(a1_wr),
    .s1_byteenable(a1_be), .s1_writedata(a1_wd), .s1_readdata(a1_q), .s1_readdatavalid(a1_v),
    .s1_waitrequest(a1_wait),
    .s2_address(a2_addr), .s2_chipselect(a2_cs), .s2_read(a2_rd), .s2_write(a2_wr),
    .s2_byteenable(a2_be), .s2_writedata(a2_wd), .s2_readdata(a2_q), .s2_readdatavalid(a2_v),
    .s2_waitrequest(a2_wait), .init_done(a_done)
  );
  nios_buffer_dpram #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) ub (
    .clk(clk), .reset(b_reset),
    .s1_address(b1_addr), .s1_chipselect(b1_cs), .s1_read(b1_rd), .s1_write(b1_wr),
    .s1_byteenable(b1_be), .s1_writedata(b1_wd), .s1_readdata(b1_q), .s1_readdatavalid(b1_v),
    .s1_waitrequest(b1_wait),
    .s2_address(b2_addr), .s2_chipselect(b2_cs), .s2_read(b2_rd), .s2_write(b2_wr),
    .s2_byteenable(b2_be), .s2_writedata(b2_wd), .s2_readdata(b2_q), .s2_readdatavalid(b2_v),
    .s2_waitrequest(b2_wait), .init_done(b_done)
  );
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic a1_drv(input logic rd, input logic wr, input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
    a1_cs = rd | wr; a1_rd = rd; a1_wr = wr; a1_addr = ad; a1_wd = d; a1_be = be;
  endtask
  task automatic a2_drv(input logic rd, input logic wr, input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
    a2_cs = rd | wr; a2_rd = rd; a2_wr = wr; a2_addr = ad; a2_wd = d; a2_be = be;
  endtask
  task automatic b1_drv(input logic rd, input logic wr, input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be);
    b1_cs = rd | wr; b1_rd = rd; b1_wr = wr; b1_addr = ad; b1_wd = d; b1_be = be;
  endtask
  initial begin
    a_reset = 1'b1;
    b_reset = 1'b1;
    a1_drv(0, 0, 0, 0, 0);
    a2_drv(0, 0, 0, 0, 0);
    b1_drv(0, 0, 0, 0, 0);
    b2_cs = 0; b2_rd = 0; b2_wr = 0; b2_addr = '0; b2_wd = '0; b2_be = '0;
    step;
    step;
    check("rst_a_wait", a1_wait, 1);
    check("rst_a_done", a_done, 0);
    check("rst_a_valid", a1_v, 0);
    check("rst_a_data", a1_q, 0);
    check("rst_b_valid", b1_v, 0);
    check("rst_b_data", b1_q, 0);
    a_reset = 1'b0;
    b_reset = 1'b0;
    a1_drv(1, 0, 2, 0, 0);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) step;
      check($sformatf("sweep_b_wait_%0d", k), b1_wait, k < 16);
      check($sformatf("sweep_b_done_%0d", k), b_done, k >= 16);
      check($sformatf("sweep_a_wait_%0d", k), a2_wait, k < 10);
      check($sformatf("stall_a_valid_%0d", k), a1_v, k == 11);
      if (k == 11) a1_drv(0, 0, 0, 0, 0);
    end
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) b1_drv(1, 0, 5'(i), 0, 0);
      else b1_drv(0, 0, 0, 0, 0);
      step;
      check($sformatf("b_clr_valid_%0d", i), b1_v, i > 0);
      if (i > 0) check($sformatf("b_clr_data_%0d", i - 1), b1_q, 0);
    end
    step;
    check("b_clr_valid_end", b1_v, 0);
    for (int i = 0; i < 10; i++) begin
      a1_drv(0, 1, 4'(i), 32'h01010101 * (i + 1), 4'hf);
      step;
    end
    a1_drv(1, 0, 9, 0, 0);
    step;
    check("a_pattern9", a1_q, 32'h0A0A0A0A);
    a1_drv(0, 0, 0, 0, 0);
    a_reset = 1'b1;
    step;
    a_reset = 1'b0;
    repeat (6) step;
    a_reset = 1'b1;
    #1;
    check("midsweep_rst_wait", a1_wait, 1);
    check("midsweep_rst_done", a_done, 0);
    check("midsweep_rst_valid", a1_v, 0);
    step;
    a_reset = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step;
      check($sformatf("resweep_a_wait_%0d", k), a1_wait, k < 10);
    end
    for (int i = 0; i < 10; i++) begin
      a1_drv(1, 0, 4'(i), 0, 0);
      step;
      check($sformatf("a_clr_valid_%0d", i), a1_v, 1);
      check($sformatf("a_clr_data_%0d", i), a1_q, 0);
    end
    a1_drv(0, 0, 0, 0, 0);
    step;
    check("a_clr_valid_end", a1_v, 0);
    a1_drv(0, 1, 5, 32'h11223344, 4'hf);
    step;
    a1_drv(0, 1, 5, 32'hDEADBEEF, 4'b0101);
    step;
    a1_drv(1, 0, 5, 0, 0);
    step;
    check("a_be_valid", a1_v, 1);
    check("a_be_data", a1_q, 32'h11AD33EF);
    a1_drv(0, 0, 0, 0, 0);
    step;
    check("a_pulse_end", a1_v, 0);
    check("a_data_held", a1_q, 32'h11AD33EF);
    b1_drv(0, 1, 5, 32'h11223344, 4'hf);
    step;
    b1_drv(0, 1, 5, 32'hDEADBEEF, 4'b0101);
    step;
    b1_drv(1, 0, 5, 0, 0);
    step;
    check("b_lat2_early", b1_v, 0);
    b1_drv(0, 0, 0, 0, 0);
    step;
    check("b_lat2_valid", b1_v, 1);
    check("b_lat2_data", b1_q, 32'h11AD33EF);
    step;
    check("b_lat2_end", b1_v, 0);
    check("b_lat2_held", b1_q, 32'h11AD33EF);
    a1_drv(0, 1, 7, 32'hAAAAAAAA, 4'b0011);
    a2_drv(0, 1, 7, 32'hBBBBBBBB, 4'b1111);
    step;
    a2_drv(0, 0, 0, 0, 0);
    a1_drv(1, 0, 7, 0, 0);
    step;
    check("collide_full", a1_q, 32'hBBBBAAAA);
    a1_drv(0, 1, 7, 32'h000000CC, 4'b0001);
    a2_drv(0, 1, 7, 32'hDD000000, 4'b1000);
    step;
    a2_drv(0, 0, 0, 0, 0);
    a1_drv(1, 0, 7, 0, 0);
    step;
    check("collide_disjoint", a1_q, 32'hDDBBAACC);
    a1_drv(0, 1, 3, 32'h12345678, 4'hf);
    a2_drv(1, 0, 3, 0, 0);
    step;
    check("rdw_valid", a2_v, 1);
    check("rdw_old", a2_q, 0);
    a1_drv(0, 0, 0, 0, 0);
    step;
    check("rdw_new", a2_q, 32'h12345678);
    a2_drv(0, 0, 0, 0, 0);
    a1_drv(1, 1, 4, 32'h00000055, 4'hf);
    step;
    check("rw_no_valid", a1_v, 0);
    a1_drv(1, 0, 4, 0, 0);
    step;
    check("rw_written", a1_q, 32'h00000055);
    a1_drv(0, 1, 12, 32'hFFFFFFFF, 4'hf);
    a2_drv(0, 1, 10, 32'hEEEEEEEE, 4'hf);
    step;
    a2_drv(0, 0, 0, 0, 0);
    a1_drv(1, 0, 12, 0, 0);
    step;
    check("oor_valid", a1_v, 1);
    check("oor_data", a1_q, 0);
    a1_drv(1, 0, 4, 0, 0);
    step;
    a1_drv(1, 0, 15, 0, 0);
    step;
    check("oor15_data", a1_q, 0);
    exp_a = '{0, 0, 0, 32'h12345678, 32'h00000055, 32'h11AD33EF, 0, 32'hDDBBAACC, 0, 0};
    for (int i = 0; i < 10; i++) begin
      a1_drv(1, 0, 4'(i), 0, 0);
      step;
      check($sformatf("final_word_%0d", i), a1_q, exp_a[i]);
    end
    a1_drv(0, 0, 0, 0, 0);
    b1_drv(1, 0, 5, 0, 0);
    step;
    b1_drv(0, 0, 0, 0, 0);
    b_reset = 1'b1;
    #1;
    check("flush_valid_now", b1_v, 0);
    check("flush_data", b1_q, 0);
    step;
    check("flush_valid_next", b1_v, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
